rf_alu_seq_ctrl: RTL

Multicycle sequencer for the 16-bit register-file + ALU datapath. It fetches 16-bit instructions over a req/ack instruction-memory handshake and owns the PC. It decodes each instruction into the datapath controls: register addresses, ALU source selects, alu_ctrl, wr_e and e_flag. It also writes incremented or branch-target values from alu_out back into the PC.

---
 rtl/rf_alu_seq_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rf_alu_seq_ctrl.sv
// Multicycle fetch/decode sequencer for the 16-bit regfile + ALU datapath.
// Optional single-step gating is enabled by defining CTRL_SINGLE_STEP_EN.
module rf_alu_seq_ctrl #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic [15:0]     alu_out,
  input  logic            z,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      instr,
  output logic [2:0]      wr_addr,
  output logic [2:0]      rd_addr_a,
  output logic [2:0]      rd_addr_b,
  output logic            wr_e,
  output logic            e_flag,
  output logic            alu_srca,
  output logic [1:0]      alu_srcb,
  output logic [1:0]      alu_ctrl,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PCINC = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
`ifdef CTRL_SINGLE_STEP_EN
    ,
    S_STEP  = 3'd5
`endif
  } state_t;

  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_BR   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] ir;
  logic        ld_ir;
  logic        ld_pc;
  logic        inc_ret;

  logic [2:0] op;
  logic       is_alu;
  logic       is_addi;
  logic       take_br;

  assign op      = ir[15:13];
  assign is_alu  = ~op[2];
  assign is_addi = (op == OP_ADDI);
  assign take_br = (op == OP_BR) | ((op == OP_BEQ) & z);

  assign imem_addr = pc;
  assign instr     = ir[7:0];
  assign halted    = (state_q == S_HALT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    wr_addr   = 3'd0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_e      = 1'b0;
    e_flag    = 1'b0;
    alu_srca  = 1'b0;
    alu_srcb  = 2'b00;
    alu_ctrl  = 2'b00;
    ld_ir     = 1'b0;
    ld_pc     = 1'b0;
    inc_ret   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_ir   = 1'b1;
          state_d = S_PCINC;
        end
      end
      S_PCINC: begin
        alu_srcb = 2'b01;
        alu_ctrl = 2'b10;
        ld_pc    = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        inc_ret = 1'b1;
        unique case (1'b1)
          is_alu, is_addi: begin
            alu_srca  = 1'b1;
            alu_srcb  = is_addi ? 2'b10 : 2'b00;
            // ADD=10 SUB=11 AND=00 OR=01 falls out of the opcode bits
            alu_ctrl  = is_addi ? 2'b10 : {~op[1], op[0]};
            rd_addr_a = ir[9:7];
            rd_addr_b = ir[6:4];
            wr_addr   = ir[12:10];
            wr_e      = 1'b1;
            e_flag    = 1'b1;
          end
          take_br: begin
            alu_srcb = 2'b11;
            alu_ctrl = 2'b10;
            ld_pc    = 1'b1;
          end
          default: ;
        endcase
        if (op == OP_HALT) state_d = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
        else state_d = S_STEP;
`else
        else state_d = S_FETCH;
`endif
      end
      S_HALT: ;
`ifdef CTRL_SINGLE_STEP_EN
      S_STEP: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (ld_ir)   ir      <= imem_data;
      if (ld_pc)   pc      <= PC_W'(alu_out);
      if (inc_ret) retired <= retired + 16'd1;
    end
  end

endmodule
